uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO with an AXI-Stream style write port.
// Define UART_TX_PARITY_EN to build in the optional parity bit (odd/even via parity_mode).
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [15:0]                          prescale,
  input  logic [1:0]                           parity_mode,
  input  logic                                 stop2,
  output logic                                 txd,
  output logic                                 busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [18:0]           baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [15:0]           prescale_q, prescale_d;
  logic                  stop2_q, stop2_d;
  logic                  txd_q, txd_d;
  logic                  push, pop, start_frame, can_pop, baud_done;
  logic [18:0]           reload;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
`else
  logic                  unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  assign s_axis_tready = (count_q != CW'(FIFO_DEPTH));
  assign push          = s_axis_tvalid & s_axis_tready;
  assign can_pop       = (count_q != '0) && (prescale != 16'd0);
  assign baud_done     = (baud_q == '0);
  assign reload        = {prescale_q, 3'b000} - 19'd1;
  assign busy          = (state_q != ST_IDLE);
  assign txd           = txd_q;
  assign fifo_count    = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    prescale_d  = prescale_q;
    stop2_d     = stop2_q;
    pop         = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
`endif

    if (state_q != ST_IDLE && !baud_done) begin
      baud_d = baud_q - 19'd1;
    end

    case (state_q)
      ST_IDLE: start_frame = can_pop;
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          baud_d  = reload;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = reload;
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          baud_d  = reload;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          if (stop2_q && bit_q == 4'd0) begin
            bit_d  = 4'd1;
            baud_d = reload;
          end else if (can_pop) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame settings are captured at the pop so mid-frame input changes only affect the next frame.
    if (start_frame) begin
      pop        = 1'b1;
      state_d    = ST_START;
      prescale_d = prescale;
      stop2_d    = stop2;
      baud_d     = {prescale, 3'b000} - 19'd1;
      shift_d    = mem[rd_ptr_q];
      bit_d      = '0;
`ifdef UART_TX_PARITY_EN
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d  = (^mem[rd_ptr_q]) ^ (parity_mode == 2'b01);
`endif
    end

    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_bit_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // NOTE: FIFO storage has no reset; the count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_axis_tdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      prescale_q <= '0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      prescale_q <= prescale_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule
